seq_tx1010: RTL

- Parallel-to-serial bit-stream transmitter. It is the source end of the serial `seq_in` wire that our Moore 1010 sequence detector consumes.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on `seq_out`.
- Keeps a reference count of overlapping "1010" occurrences on its own output. Benches compare this count against the detector's pulse count.

---
 rtl/seq_tx1010.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_tx1010.sv
// ----------------------------------------------------------------------------
// seq_tx1010 : parallel-to-serial bit-stream transmitter with a reference
//              counter of overlapping "1010" patterns seen on its own output.
//
// Ports
//   clock      in   system clock, all state updates on the rising edge
//   reset      in   synchronous active-low reset (priority over everything)
//   data_in    in   WIDTH-bit word to send, bit WIDTH-1 goes first
//   valid      in   data_in is valid (held stable by the source until accepted)
//   ready      out  a word can be accepted this cycle (combinational from state)
//   seq_out    out  serial stream, 0 when idle
//   seq_valid  out  seq_out carries a data bit this cycle
//   done       out  high while the LSB of a word is on seq_out
//   clear_cnt  in   synchronous clear of match_cnt and of the pattern history
//   match_cnt  out  saturating count of overlapping "1010" patterns on seq_out
// ----------------------------------------------------------------------------
module seq_tx1010 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             done,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    // Holds the bits still to be sent, MSB-aligned; the bit on the wire
    // lives in seq_out_q, so the register is loaded pre-shifted by one.
    logic [WIDTH-1:0]  shreg_q,     shreg_d;
    logic [BC_W-1:0]   bitcnt_q,    bitcnt_d;
    logic              seq_out_q,   seq_out_d;
    logic              seq_valid_q, seq_valid_d;
    logic              done_q,      done_d;
    logic [2:0]        hist_q,      hist_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

    logic              ready_s;
    logic              accept_s;
    logic              hit_s;
    logic              sat_s;

    // Handshake: ready in IDLE, or while the LSB of the current word is out.
    always_comb begin
        ready_s  = (state_q == IDLE) || ((state_q == SHIFT) && (bitcnt_q == {BC_W{1'b0}}));
        accept_s = valid && ready_s;
    end

    // Transmit FSM next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        seq_out_d   = seq_out_q;
        seq_valid_d = seq_valid_q;
        if (accept_s) begin
            state_d     = SHIFT;
            shreg_d     = {data_in[WIDTH-2:0], 1'b0};
            bitcnt_d    = BC_W'(WIDTH - 1);
            seq_out_d   = data_in[WIDTH-1];
            seq_valid_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    shreg_d     = {WIDTH{1'b0}};
                    bitcnt_d    = {BC_W{1'b0}};
                    seq_out_d   = 1'b0;
                    seq_valid_d = 1'b0;
                end
                SHIFT: begin
                    if (bitcnt_q != {BC_W{1'b0}}) begin
                        shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                        bitcnt_d    = bitcnt_q - BC_W'(1);
                        seq_out_d   = shreg_q[WIDTH-1];
                        seq_valid_d = 1'b1;
                    end else begin
                        // LSB just went out and no follow-on word: go quiet.
                        state_d     = IDLE;
                        shreg_d     = {WIDTH{1'b0}};
                        bitcnt_d    = {BC_W{1'b0}};
                        seq_out_d   = 1'b0;
                        seq_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    shreg_d     = {WIDTH{1'b0}};
                    bitcnt_d    = {BC_W{1'b0}};
                    seq_out_d   = 1'b0;
                    seq_valid_d = 1'b0;
                end
            endcase
        end
        // done marks the cycle in which the LSB sits on the wire.
        done_d = (state_d == SHIFT) && (bitcnt_d == {BC_W{1'b0}});
    end

    // Pattern history and saturating "1010" counter next values.
    always_comb begin
        hit_s       = ({hist_q, seq_out_q} == 4'b1010);
        sat_s       = (match_cnt_q == {CNT_W{1'b1}});
        match_cnt_d = match_cnt_q;
        hist_d      = {hist_q[1:0], seq_out_q};
        if (clear_cnt) begin
            match_cnt_d = {CNT_W{1'b0}};
            hist_d      = 3'b000;
        end else begin
            if (hit_s && !sat_s) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end else begin
                match_cnt_d = match_cnt_q;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= {WIDTH{1'b0}};
            bitcnt_q    <= {BC_W{1'b0}};
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            done_q      <= 1'b0;
            hist_q      <= 3'b000;
            match_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
            done_q      <= done_d;
            hist_q      <= hist_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign ready     = ready_s;
    assign seq_out   = seq_out_q;
    assign seq_valid = seq_valid_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_q;

endmodule
